// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants and the write-back source decode,
// reused by the M, D and W stages.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic [1:0] {
    SrcAlu,
    SrcMem,
    SrcLoadExt,
    SrcPc8
  } wb_src_e;

  function automatic wb_src_e wb_src_sel(input logic [5:0] op, input logic [5:0] funct);
    wb_src_e src;
    src = SrcAlu;
    if (op == OP_LW) begin
      src = SrcMem;
    end else if (op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU) begin
      src = SrcLoadExt;
    end else if (op == OP_JAL || (op == OP_RTYPE && funct == FN_JALR)) begin
      src = SrcPc8;
    end
    return src;
  endfunction

endpackage

// File: rtl/grf_writeback_if.sv
// W-stage bundle: pipeline register outputs in, commit/forward/read results out.
interface grf_writeback_if;

  logic [31:0] pc8W;
  logic [31:0] dmW;
  logic [31:0] aluoutW;
  logic [4:0]  waW;
  logic [31:0] instrW;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wdW;
  logic        weW;
  logic [31:0] retired;

  modport master (
    output pc8W, dmW, aluoutW, waW, instrW, ra1, ra2,
    input  rd1, rd2, wdW, weW, retired
  );

  modport slave (
    input  pc8W, dmW, aluoutW, waW, instrW, ra1, ra2,
    output rd1, rd2, wdW, weW, retired
  );

endinterface

// File: rtl/grf_writeback_load_ext.sv
// Sub-word load extraction: picks the addressed byte/halfword out of the
// aligned memory word and sign- or zero-extends it.
module wb_load_ext
  import mips_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] dm_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dm_i[8*addr_lo_i +: 8];
    // Halfword loads ignore the low address bit.
    half_sel = addr_lo_i[1] ? dm_i[31:16] : dm_i[15:0];
  end

  always_comb begin
    ext_o = '0;
    case (op_i)
      OP_LB:   ext_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_o = {24'h0, byte_sel};
      OP_LH:   ext_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_o = {16'h0, half_sel};
      default: ext_o = '0;
    endcase
  end

endmodule

// File: rtl/grf_writeback.sv
// Write-back stage: selects commit data, writes the 32x32 register file,
// serves two bypassed read ports and counts retired instructions.
module grf_writeback
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  grf_writeback_if.slave  wb
);

  logic [31:0] gpr_q [32];
  logic [31:0] retired_q, retired_d;
  logic [31:0] load_val;
  logic [31:0] wd;
  logic        we;
  wb_src_e     src;
  logic        unused_instr;

  assign unused_instr = ^wb.instrW[25:6];

  wb_load_ext u_load_ext (
    .op_i      (wb.instrW[31:26]),
    .dm_i      (wb.dmW),
    .addr_lo_i (wb.aluoutW[1:0]),
    .ext_o     (load_val)
  );

  always_comb begin
    src = wb_src_sel(wb.instrW[31:26], wb.instrW[5:0]);
    wd  = wb.aluoutW;
    unique case (src)
      SrcMem:     wd = wb.dmW;
      SrcLoadExt: wd = load_val;
      SrcPc8:     wd = wb.pc8W;
      default:    wd = wb.aluoutW;
    endcase
  end

  assign we = (wb.waW != 5'd0);

  always_comb begin
    retired_d = retired_q;
    if (wb.instrW != 32'h0) begin
      retired_d = retired_q + 32'd1;
    end
  end

  // gpr_q[0] is never written because we requires a nonzero index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
      retired_q <= '0;
    end else begin
      if (we) begin
        gpr_q[wb.waW] <= wd;
      end
      retired_q <= retired_d;
    end
  end

  // Same-cycle write-through so decode sees the value being committed.
  always_comb begin
    wb.rd1 = gpr_q[wb.ra1];
    if (wb.ra1 == 5'd0) begin
      wb.rd1 = '0;
    end else if (we && wb.ra1 == wb.waW) begin
      wb.rd1 = wd;
    end
  end

  always_comb begin
    wb.rd2 = gpr_q[wb.ra2];
    if (wb.ra2 == 5'd0) begin
      wb.rd2 = '0;
    end else if (we && wb.ra2 == wb.waW) begin
      wb.rd2 = wd;
    end
  end

  assign wb.wdW     = wd;
  assign wb.weW     = we;
  assign wb.retired = retired_q;

endmodule

// File: tb/tb_grf_writeback.sv
// Self-checking bench for grf_writeback: scoreboard of expected values per scenario.
module tb_grf_writeback;

  localparam logic [31:0] InstrAdd  = 32'h0000_0020;
  localparam logic [31:0] InstrJal  = {6'h03, 26'h0};
  localparam logic [31:0] InstrJalr = {6'h00, 20'h0, 6'h09};

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] mdl [32];

  grf_writeback_if bus ();

  grf_writeback dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.pc8W    = '0;
    bus.dmW     = '0;
    bus.aluoutW = '0;
    bus.waW     = '0;
    bus.instrW  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_alu(input logic [4:0] wa, input logic [31:0] val);
    bus.instrW  = InstrAdd;
    bus.aluoutW = val;
    bus.waW     = wa;
  endtask

  task automatic test_reset();
    // state after the power-on reset
    idle();
    bus.ra1 = 5'd5;
    bus.ra2 = 5'd31;
    #1;
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.retired !== exp_v) begin
      errors++;
      $display("FAIL reset_retired: got %h expected %h", bus.retired, exp_v);
    end
    checks++;
    if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h expected 0/0", bus.rd1, bus.rd2);
    end
    checks++;
    if (bus.wdW !== 32'h0 || bus.weW !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb_idle: got wd=%h we=%b expected 0/0", bus.wdW, bus.weW);
    end
    // preload gpr[5]=0x1234 and retired=7
    @(negedge clk);
    drive_alu(5'd5, 32'h0000_1234);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_alu(5'd0, 32'h0);
    end
    @(negedge clk);
    idle();
    #1;
    exp_q.push_back(32'd7);
    exp_q.push_back(32'h0000_1234);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.retired !== exp_v) begin
      errors++;
      $display("FAIL preload_retired: got %h expected %h", bus.retired, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd1 !== exp_v) begin
      errors++;
      $display("FAIL preload_gpr5: got %h expected %h", bus.rd1, exp_v);
    end
    // reset concurrent with a write and a count
    drive_alu(5'd5, 32'h0000_BEEF);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd1 !== exp_v) begin
      errors++;
      $display("FAIL midreset_gpr5: got %h expected %h", bus.rd1, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.retired !== exp_v) begin
      errors++;
      $display("FAIL midreset_retired: got %h expected %h", bus.retired, exp_v);
    end
  endtask

  task automatic test_loads();
    logic [5:0]  ops  [5] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23};
    logic [1:0]  addr [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      bus.dmW     = 32'h80FF_7F01;
      bus.instrW  = {ops[i], 26'h0};
      bus.aluoutW = {28'h0000_100, 2'b00, addr[i]};
      bus.waW     = 5'd3;
      exp_q.push_back(exps[i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.wdW !== exp_v) begin
        errors++;
        $display("FAIL load_op%h_a%0d: got %h expected %h", ops[i], addr[i], bus.wdW, exp_v);
      end
    end
    // the last load (lw) commits to gpr[3]
    @(negedge clk);
    idle();
    bus.ra1 = 5'd3;
    exp_q.push_back(32'h80FF_7F01);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd1 !== exp_v) begin
      errors++;
      $display("FAIL load_commit: got %h expected %h", bus.rd1, exp_v);
    end
  endtask

  task automatic test_link();
    @(negedge clk);
    idle();
    bus.instrW  = InstrJal;
    bus.pc8W    = 32'h0000_3008;
    bus.aluoutW = 32'h1111_1111;
    bus.waW     = 5'd31;
    exp_q.push_back(32'h0000_3008);
    @(negedge clk);
    bus.instrW  = InstrJalr;
    bus.pc8W    = 32'h0000_4410;
    bus.aluoutW = 32'h2222_2222;
    bus.waW     = 5'd4;
    exp_q.push_back(32'h0000_4410);
    @(negedge clk);
    idle();
    bus.ra1 = 5'd31;
    bus.ra2 = 5'd4;
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd1 !== exp_v) begin
      errors++;
      $display("FAIL jal_link: got %h expected %h", bus.rd1, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd2 !== exp_v) begin
      errors++;
      $display("FAIL jalr_link: got %h expected %h", bus.rd2, exp_v);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle();
    drive_alu(5'd9, 32'hDEAD_BEEF);
    bus.ra1 = 5'd9;
    bus.ra2 = 5'd9;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'hDEAD_BEEF);
      exp_q.push_back(32'hDEAD_BEEF);
      exp_q.push_back(k == 0 ? 32'h1 : 32'h0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd1 !== exp_v) begin
        errors++;
        $display("FAIL bypass_rd1_c%0d: got %h expected %h", k, bus.rd1, exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd2 !== exp_v) begin
        errors++;
        $display("FAIL bypass_rd2_c%0d: got %h expected %h", k, bus.rd2, exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if ({31'h0, bus.weW} !== exp_v) begin
        errors++;
        $display("FAIL bypass_we_c%0d: got %b expected %h", k, bus.weW, exp_v);
      end
      @(negedge clk);
      idle();
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive_alu(5'd0, 32'hFFFF_FFFF);
    bus.ra1 = 5'd0;
    bus.ra2 = 5'd9;
    #1;
    checks++;
    if (bus.weW !== 1'b0) begin
      errors++;
      $display("FAIL zero_we: got %b expected 0", bus.weW);
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h0);
      exp_q.push_back(32'hDEAD_BEEF);
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd1 !== exp_v) begin
        errors++;
        $display("FAIL zero_rd1_c%0d: got %h expected %h", k, bus.rd1, exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd2 !== exp_v) begin
        errors++;
        $display("FAIL zero_untouched_c%0d: got %h expected %h", k, bus.rd2, exp_v);
      end
      @(negedge clk);
      idle();
      #1;
    end
  endtask

  task automatic test_counter();
    logic [7:0] is_instr = 8'b1010_1101;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (is_instr[i]) begin
        drive_alu(5'd0, 32'h0);
      end else if (i == 4) begin
        // bubble opcode but nonzero destination: written, not counted
        bus.waW     = 5'd7;
        bus.aluoutW = 32'h0000_0077;
      end
      @(negedge clk);
    end
    idle();
    bus.ra1 = 5'd7;
    exp_q.push_back(32'd5);
    exp_q.push_back(32'h0000_0077);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.retired !== exp_v) begin
      errors++;
      $display("FAIL count_five: got %h expected %h", bus.retired, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd1 !== exp_v) begin
      errors++;
      $display("FAIL bubble_write: got %h expected %h", bus.rd1, exp_v);
    end
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    drive_alu(5'd0, 32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    idle();
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.retired !== exp_v) begin
      errors++;
      $display("FAIL count_wrap: got %h expected %h", bus.retired, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  wa;
    logic [31:0] val;
    do_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 24; i++) begin
      wa  = 5'($urandom_range(0, 31));
      val = $urandom;
      drive_alu(wa, val);
      if (wa != 5'd0) mdl[wa] = val;
      @(negedge clk);
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      bus.ra1 = 5'(i);
      bus.ra2 = 5'((i * 7) % 32);
      exp_q.push_back(mdl[i]);
      exp_q.push_back(mdl[(i * 7) % 32]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd1 !== exp_v) begin
        errors++;
        $display("FAIL b2b_rd1_r%0d: got %h expected %h", i, bus.rd1, exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd2 !== exp_v) begin
        errors++;
        $display("FAIL b2b_rd2_r%0d: got %h expected %h", (i * 7) % 32, bus.rd2, exp_v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b0;
    bus.ra1 = '0;
    bus.ra2 = '0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_loads();
    test_link();
    test_bypass();
    test_zero_reg();
    test_counter();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
